// File: rtl/deskew_lane.sv
// deskew_lane: one lane of the receive-side deskew chain.
// Delays the lane data and its valid bit by DLT cycles. DLT=0 degenerates to
// a pure wire, which the last lane of the chain uses.
//
// Ports:
//   clk    in   1    clock, rising edge
//   rst_n  in   1    asynchronous active-low reset (clears valid and data)
//   clr    in   1    synchronous flush of the valid bits only
//   xi     in   SDW  lane data in
//   vi     in   1    lane valid in
//   xo     out  SDW  lane data delayed by DLT cycles
//   vo     out  1    lane valid delayed by DLT cycles
module deskew_lane #(
    parameter int SDW = 8,
    parameter int DLT = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic [SDW-1:0] xi,
    input  logic           vi,
    output logic [SDW-1:0] xo,
    output logic           vo
);

    generate
        if (DLT == 0) begin : g_wire
            // Zero-depth lane: nothing is registered, so the clock and reset
            // have no job here.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;

            // Gating the valid with clr here is harmless: the top already
            // forces vo low and suppresses mismatch detection while clr=1.
            assign xo = xi;
            assign vo = vi & ~clr;
        end else begin : g_pipe
            logic [SDW-1:0] d_p [DLT];
            logic [DLT-1:0] vld_p;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p <= '0;
                    for (int k = 0; k < DLT; k++) begin
                        d_p[k] <= '0;
                    end
                end else begin
                    // Stage boundary: data shifts every cycle, valids are
                    // flushed by clr, including the bit entering this cycle.
                    d_p[0]   <= xi;
                    vld_p[0] <= vi & ~clr;
                    for (int k = 1; k < DLT; k++) begin
                        d_p[k]   <= d_p[k-1];
                        vld_p[k] <= vld_p[k-1] & ~clr;
                    end
                end
            end

            assign xo = d_p[DLT-1];
            assign vo = vld_p[DLT-1];
        end
    endgenerate

endmodule

// File: rtl/deskew_chain.sv
// deskew_chain: realigns a lane-staggered bus (lane i arriving i cycles after
// lane 0) so that every lane of a vector leaves on the same cycle. Lane i is
// delayed by DN-1-i cycles; total latency from lane 0 is DN-1 cycles. The
// per-lane valids are combined into one aligned valid, and a sticky flag
// records the first vector whose lane valids did not line up.
//
// Ports:
//   clk       in   1   clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   xi        in   DW  skewed data, lane i = xi[SDW*i +: SDW]
//   vi        in   DN  skewed per-lane valids
//   clr       in   1   synchronous flush of in-flight valids and error state
//   xo        out  DW  aligned data (meaningful only while vo=1)
//   vo        out  1   aligned vector valid
//   err       out  1   sticky misalignment flag
//   err_mask  out  DN  aligned valid vector captured at the first error
module deskew_chain #(
    parameter int DW = 64,
    parameter int DN = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] xi,
    input  logic [DN-1:0] vi,
    input  logic          clr,
    output logic [DW-1:0] xo,
    output logic          vo,
    output logic          err,
    output logic [DN-1:0] err_mask
);

    localparam int SDW = DW / DN;

    logic [DN-1:0] av;
    logic          mismatch;

    genvar i;
    generate
        for (i = 0; i < DN; i++) begin : g_lane
            deskew_lane #(
                .SDW (SDW),
                .DLT (DN - 1 - i)
            ) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clr),
                .xi    (xi[SDW*i +: SDW]),
                .vi    (vi[i]),
                .xo    (xo[SDW*i +: SDW]),
                .vo    (av[i])
            );
        end
    endgenerate

    // Output stage: a vector is valid only when every lane's delayed valid
    // is set; a partial set is a misalignment.
    assign vo       = (&av) & ~clr;
    assign mismatch = (|av) & ~(&av) & ~clr;

    // Only the first mismatch is recorded; later ones leave err_mask alone
    // until clr or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err      <= 1'b0;
            err_mask <= '0;
        end else if (clr) begin
            err      <= 1'b0;
            err_mask <= '0;
        end else if (mismatch && !err) begin
            err      <= 1'b1;
            err_mask <= av;
        end
    end

endmodule

// File: tb/tb_deskew_chain.sv
module tb_deskew_chain;

    localparam int DW  = 64;
    localparam int DN  = 8;
    localparam int SDW = DW / DN;
    localparam int LAT = DN - 1;
    localparam int NS  = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic [DW-1:0] xi;
    logic [DN-1:0] vi;
    logic [DW-1:0] xo;
    logic          vo;
    logic          err;
    logic [DN-1:0] err_mask;

    always #5 clk = ~clk;

    deskew_chain #(.DW(DW), .DN(DN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .xi       (xi),
        .vi       (vi),
        .clr      (clr),
        .xo       (xo),
        .vo       (vo),
        .err      (err),
        .err_mask (err_mask)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;
    logic done = 1'b0;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t exp_q[$];

    // Per-slot stimulus schedule, filled by add_vec and consumed by run.
    logic [DW-1:0] sx [NS];
    logic [DN-1:0] sv [NS];
    logic          sc [NS];
    logic          se [NS];
    logic [DW-1:0] sd [NS];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic clear_slots();
        for (int j = 0; j < NS; j++) begin
            sx[j] = '0;
            sv[j] = '0;
            sc[j] = 1'b0;
            se[j] = 1'b0;
            sd[j] = '0;
        end
    endtask

    // Skew a vector the way the transmit side does: lane i at slot s+i.
    task automatic add_vec(input int s, input logic [DW-1:0] v, input logic [DN-1:0] m,
                           input logic expect_out);
        for (int i = 0; i < DN; i++) begin
            sx[s+i][SDW*i +: SDW] = v[SDW*i +: SDW];
            sv[s+i][i]            = m[i];
        end
        if (expect_out) begin
            se[s] = 1'b1;
            sd[s] = v;
        end
    endtask

    task automatic run(input int n, input int rlo, input int rhi, input int clo, input int chi);
        for (int j = 0; j < n; j++) begin
            xi  = sx[j];
            vi  = sv[j];
            clr = sc[j];
            if (se[j]) exp_q.push_back('{data: sd[j], due: cyc + LAT});
            if (j == rlo) begin
                rst_n = 1'b0;
                #1;
                chk("vo_at_async_rst", {63'd0, vo}, 64'd0);
                chk("err_at_async_rst", {63'd0, err}, 64'd0);
                chk("mask_at_async_rst", {56'd0, err_mask}, 64'd0);
            end
            if (j == rhi) rst_n = 1'b1;
            @(posedge clk);
            #1;
            if (j >= clo && j <= chi) chk("err_cleared_by_clr", {63'd0, err}, 64'd0);
        end
        xi  = '0;
        vi  = '0;
        clr = 1'b0;
        clear_slots();
    endtask

    // Monitor: every cycle, compares vo against the scoreboard and the data
    // of each expected vector on the cycle it is due.
    always @(negedge clk) begin
        if (!done) begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL missed_vector: no output, want %h at cycle %0d",
                         exp_q[0].data, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                chk("vo_expected", {63'd0, vo}, 64'd1);
                chk("xo_data", xo, exp_q[0].data);
                void'(exp_q.pop_front());
            end else begin
                chk("vo_idle", {63'd0, vo}, 64'd0);
            end
        end
    end

    localparam logic [DW-1:0] VEC1 = 64'h1716151413121110;

    initial begin
        clear_slots();
        rst_n = 1'b0;
        clr   = 1'b0;
        vi    = '0;
        xi    = '1;

        // Reset state: registered lanes zero, last lane follows xi.
        repeat (3) @(posedge clk);
        #2;
        chk("rst_xo", xo, 64'hFF00_0000_0000_0000);
        chk("rst_vo", {63'd0, vo}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_mask", {56'd0, err_mask}, 64'd0);
        xi = 64'hA5A5_A5A5_A5A5_A5A5;
        #1;
        chk("rst_xo_pass", xo, 64'hA500_0000_0000_0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        xi    = '0;
        repeat (2) @(posedge clk);
        #1;

        // Single aligned vector.
        add_vec(0, VEC1, 8'hFF, 1'b1);
        run(12, -1, -1, -1, -1);
        chk("single_err", {63'd0, err}, 64'd0);

        // Back-to-back loopback of 32 random vectors.
        for (int k = 0; k < 32; k++) add_vec(k, {$urandom, $urandom}, 8'hFF, 1'b1);
        run(45, -1, -1, -1, -1);
        chk("loop_err", {63'd0, err}, 64'd0);

        // Missing lane 3.
        add_vec(0, VEC1, 8'hF7, 1'b0);
        run(12, -1, -1, -1, -1);
        chk("miss_err", {63'd0, err}, 64'd1);
        chk("miss_mask", {56'd0, err_mask}, 64'h00F7);

        // Clean vector afterwards: the error state is sticky.
        add_vec(0, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
        run(12, -1, -1, -1, -1);
        chk("sticky_err", {63'd0, err}, 64'd1);
        chk("sticky_mask", {56'd0, err_mask}, 64'h00F7);

        // clr while a vector is in flight: lanes 0..3 are flushed, lanes 4..7
        // still arrive and form a misaligned vector.
        add_vec(0, VEC1, 8'hFF, 1'b0);
        sc[3] = 1'b1;
        run(12, -1, -1, 3, 6);
        chk("clr_err", {63'd0, err}, 64'd1);
        chk("clr_mask", {56'd0, err_mask}, 64'h00F0);

        // Flush the error state.
        sc[0] = 1'b1;
        run(2, -1, -1, -1, -1);
        chk("flush_err", {63'd0, err}, 64'd0);
        chk("flush_mask", {56'd0, err_mask}, 64'd0);

        // Async reset mid-stream: only vectors whose lanes all arrive after
        // reset release come out.
        for (int k = 0; k < 16; k++) add_vec(k, {$urandom, $urandom}, 8'hFF, k >= 6);
        run(30, 4, 6, -1, -1);

        sc[0] = 1'b1;
        run(2, -1, -1, -1, -1);
        chk("final_err", {63'd0, err}, 64'd0);

        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
